// File: rtl/input_conditioner_pkg.sv
// Shared sizes and field offsets for the conditioned digital-input vector.
// The peripheral block reuses the offsets for its digital-input register layout.
package input_conditioner_pkg;

    localparam int N_SW     = 16;
    localparam int N_BTN    = 5;
    localparam int N_IPIN   = 4;
    localparam int N_IN     = N_SW + N_BTN + N_IPIN;

    localparam int SW_LSB   = 0;
    localparam int BTN_LSB  = N_SW;
    localparam int IPIN_LSB = N_SW + N_BTN;

    // Debounce counter width; a single-cycle debounce still needs one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// One-bit 2-flop synchronizer + stable-count debounce with registered edge pulses.
// Latency: clean follows raw after DEBOUNCE_CYCLES+2 edges; pulses one cycle wide.
// Backpressure: none, level input sampled every cycle.
module debounce_bit
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          clean_q, clean_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any agreement between s2 and clean restarts the count, which rejects glitches.
    always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s2_q != clean_q) begin
            if (cnt_q == CNT_LAST) begin
                clean_d = s2_q;
                rise_d  = s2_q;
                fall_d  = ~s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean = clean_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Synchronizes and debounces switch/button/pin pads; emits per-bit rise/fall pulses.
// Latency: DEBOUNCE_CYCLES+2 edges from pad change to clean level, all outputs registered.
// Backpressure: none, outputs are levels and single-cycle pulses.
module input_conditioner #(
    parameter int N_SW            = input_conditioner_pkg::N_SW,
    parameter int N_BTN           = input_conditioner_pkg::N_BTN,
    parameter int N_IPIN          = input_conditioner_pkg::N_IPIN,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_SW-1:0]                 sw_raw,
    input  logic [N_BTN-1:0]                btn_raw,
    input  logic [N_IPIN-1:0]               ipin_raw,
    output logic [N_SW-1:0]                 sw,
    output logic [N_BTN-1:0]                btn,
    output logic [N_IPIN-1:0]               ipin,
    output logic [N_SW+N_BTN+N_IPIN-1:0]    rise,
    output logic [N_SW+N_BTN+N_IPIN-1:0]    fall
);

    localparam int NI       = N_SW + N_BTN + N_IPIN;
    localparam int BTN_OFS  = N_SW;
    localparam int IPIN_OFS = N_SW + N_BTN;

    logic [NI-1:0] raw_all;
    logic [NI-1:0] clean_all;

    // Same {ipin,btn,sw} packing as rise/fall, sw at the LSBs.
    assign raw_all = {ipin_raw, btn_raw, sw_raw};

    for (genvar i = 0; i < NI; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (raw_all[i]),
            .clean(clean_all[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

    assign sw   = clean_all[N_SW-1:0];
    assign btn  = clean_all[BTN_OFS +: N_BTN];
    assign ipin = clean_all[IPIN_OFS +: N_IPIN];

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4 and a sliding-window reference model.
module tb_input_conditioner;

    localparam int D  = 4;
    localparam int NI = 25;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [15:0]     sw_raw = '0;
    logic [4:0]      btn_raw = '0;
    logic [3:0]      ipin_raw = '0;
    logic [15:0]     sw;
    logic [4:0]      btn;
    logic [3:0]      ipin;
    logic [NI-1:0]   rise, fall;

    int checks = 0;
    int failures = 0;

    input_conditioner #(
        .N_SW(16), .N_BTN(5), .N_IPIN(4), .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .sw_raw(sw_raw), .btn_raw(btn_raw), .ipin_raw(ipin_raw),
        .sw(sw), .btn(btn), .ipin(ipin), .rise(rise), .fall(fall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [NI-1:0] act, input logic [NI-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: hist[k] is the pad value sampled k edges ago. A bit accepts a new
    // level when the D samples that reached the synchronizer output (2..D+1
    // edges old) all disagree with the current clean level.
    logic [NI-1:0] hist [0:D+1];
    logic [NI-1:0] m_clean = '0, m_rise = '0, m_fall = '0;
    logic          all_diff;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i <= D + 1; i++) hist[i] = '0;
            m_clean = '0;
            m_rise  = '0;
            m_fall  = '0;
        end else begin
            for (int i = D + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {ipin_raw, btn_raw, sw_raw};
            m_rise = '0;
            m_fall = '0;
            for (int b = 0; b < NI; b++) begin
                all_diff = 1'b1;
                for (int j = 2; j <= D + 1; j++)
                    if (hist[j][b] == m_clean[b]) all_diff = 1'b0;
                if (all_diff) begin
                    m_clean[b] = ~m_clean[b];
                    m_rise[b]  = m_clean[b];
                    m_fall[b]  = ~m_clean[b];
                end
            end
        end
        #1;
        chk("model_clean", {ipin, btn, sw}, m_clean);
        chk("model_rise", rise, m_rise);
        chk("model_fall", fall, m_fall);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset with all pads high
        sw_raw = 16'hFFFF; btn_raw = 5'h1F; ipin_raw = 4'hF;
        cyc(3);
        chk("rst_sw", 25'(sw), 25'h0);
        chk("rst_btn", 25'(btn), 25'h0);
        chk("rst_ipin", 25'(ipin), 25'h0);
        chk("rst_rise", rise, 25'h0);
        chk("rst_fall", fall, 25'h0);
        rst_n = 1'b1;
        cyc(5);
        chk("rel_sw_e4", 25'(sw), 25'h0);
        cyc(1);
        chk("rel_sw_e5", 25'(sw), 25'h000FFFF);
        chk("rel_btn_e5", 25'(btn), 25'h000001F);
        chk("rel_ipin_e5", 25'(ipin), 25'h000000F);
        chk("rel_rise_e5", rise, 25'h1FFFFFF);
        cyc(1);
        chk("rel_rise_e6", rise, 25'h0);
        sw_raw = '0; btn_raw = '0; ipin_raw = '0;
        cyc(10);

        // Clean press of btn[2]
        btn_raw[2] = 1'b1;
        cyc(5);
        chk("press_btn_e4", 25'(btn), 25'h0);
        cyc(1);
        chk("press_btn_e5", 25'(btn), 25'h4);
        chk("press_rise_e5", rise, 25'h0040000);
        chk("press_fall_e5", fall, 25'h0);
        cyc(1);
        chk("press_rise_e6", rise, 25'h0);
        btn_raw[2] = 1'b0;
        cyc(10);

        // Bounce on sw[0]
        sw_raw[0] = 1'b1;
        cyc(3);
        sw_raw[0] = 1'b0;
        cyc(2);
        sw_raw[0] = 1'b1;
        cyc(5);
        chk("bounce_sw_e4", 25'(sw), 25'h0);
        chk("bounce_rise_e4", rise, 25'h0);
        cyc(1);
        chk("bounce_sw_e5", 25'(sw), 25'h1);
        chk("bounce_rise_e5", rise, 25'h1);
        sw_raw[0] = 1'b0;
        cyc(10);

        // Three-cycle glitch on ipin[3]
        ipin_raw[3] = 1'b1;
        cyc(3);
        ipin_raw[3] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("glitch_pulses", rise | fall, 25'h0);
        end
        chk("glitch_ipin", 25'(ipin), 25'h0);

        // Simultaneous release of btn[0] and sw[15]
        btn_raw[0] = 1'b1; sw_raw[15] = 1'b1;
        cyc(10);
        chk("simul_set", {ipin, btn, sw}, 25'h0018000);
        btn_raw[0] = 1'b0; sw_raw[15] = 1'b0;
        cyc(5);
        chk("simul_e4", {ipin, btn, sw}, 25'h0018000);
        cyc(1);
        chk("simul_clean_e5", {ipin, btn, sw}, 25'h0);
        chk("simul_fall_e5", fall, 25'h0018000);
        cyc(1);
        chk("simul_fall_e6", fall, 25'h0);
        cyc(5);

        // Reset mid-count on sw[3]
        sw_raw[3] = 1'b1;
        cyc(4);
        rst_n = 1'b0;
        cyc(1);
        chk("midrst_sw", 25'(sw), 25'h0);
        rst_n = 1'b1;
        cyc(5);
        chk("midrst_sw_e4", 25'(sw), 25'h0);
        cyc(1);
        chk("midrst_sw_e5", 25'(sw), 25'h8);
        chk("midrst_rise_e5", rise, 25'h8);
        cyc(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
